multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore control FSM that sequences the shared multicycle datapath: one ALU, the
//  SrcA/SrcB operand muxes, a unified instruction/data memory, the register file and the PC.
//  Decodes opcode/funct and drives every mux select and write strobe, one step per clock.
//  Stalls on a memory ready handshake. Sits between the instruction register and the datapath.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode
//  OP_LW     6'h23  load word
//  OP_SW     6'h2B  store word
//  OP_BEQ    6'h04  branch if equal
//  OP_ADDI   6'h08  add immediate
//  OP_J      6'h02  jump
// PORTS
//  clk         in   1  single clock; all state updates on posedge
//  reset       in   1  synchronous, active-high
//  opcode      in   6  instruction [31:26], from the instruction register
//  funct       in   6  instruction [5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  IorD        out  1  memory address: 0=PC, 1=ALUOut
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  instruction register load
//  RegDst      out  1  write register: 0=rt, 1=rd
//  MemtoReg    out  1  write data: 0=ALUOut, 1=memory data
//  RegWrite    out  1  register file write strobe
//  ALUSrcA     out  1  SrcA: 0=PC, 1=register A
//  ALUSrcB     out  2  SrcB: 00=reg B, 01=const 4, 10=SignImm, 11=SignImm<<2
//  ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  PCSrc       out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
//  PCEn        out  1  PC load enable = PCWrite | (Branch & zero)
//  state_o     out  4  current state, for debug
// BEHAVIOUR
//  - State encoding: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 RTYPEEX6 RTYPEWB7
//    BEQEX8 ADDIEX9 ADDIWB10 JEX11.
//  - Outputs are a function of state only, except the mem_ready-qualified strobes and PCEn.
//    Any output not listed for a state is 0.
//  - Reset: state<=FETCH at the next edge. While reset=1, every strobe is forced to 0
//    combinationally: MemRead, MemWrite, IRWrite, RegWrite, PCEn. A reset in mid-instruction
//    aborts it. No partial write occurs after the reset edge.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00.
//    IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE; otherwise hold.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
//    Next state by opcode: lw/sw -> MEMADR, R -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX,
//    j -> JEX. Any other opcode -> FETCH (executes as a NOP).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMRD for lw, MEMWR for sw.
//  - MEMRD: IorD=1, MemRead=1. mem_ready -> MEMWB; otherwise hold.
//  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: IorD=1, MemWrite=1, held until mem_ready; then -> FETCH.
//  - RTYPEEX: ALUSrcA=1, ALUSrcB=00. ALUControl from funct:
//    20->add, 22->sub, 24->and, 25->or, 2A->slt, other->add. Next state RTYPEWB.
//  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//  - BEQEX: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1 (PCEn=zero) -> FETCH.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
//  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  - JEX: PCSrc=10, PCWrite=1 -> FETCH.
//  - States 12-15 are illegal: all strobes 0, next state FETCH.
//  - Latency with mem_ready tied high, in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//    Each low cycle of mem_ready in FETCH/MEMRD/MEMWR adds one cycle.
// TESTING
//  1. reset=1 for 2 cycles, mem_ready=1 -> state_o=0; all strobes 0 while reset is high.
//     First FETCH after release gives IRWrite=1, PCEn=1.
//  2. opcode=23, mem_ready=1 -> states 0,1,2,3,4,0. RegWrite=1 only in state 4, with MemtoReg=1.
//  3. opcode=2B, mem_ready low for 3 cycles in MEMWR -> MemWrite high 4 cycles, IorD=1.
//     RegWrite is never asserted.
//  4. opcode=00, funct=22 -> ALUControl=110 in RTYPEEX; RTYPEWB gives RegDst=1, RegWrite=1.
//     funct=3F -> ALUControl=010.
//  5. opcode=04: zero=1 -> PCEn=1, PCSrc=01 in BEQEX; zero=0 -> PCEn=0. Returns to FETCH.
//  6. opcode=3F -> DECODE then FETCH with no strobes asserted.
//     reset asserted in MEMRD -> state 0 next cycle; RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared-ALU multicycle datapath: decodes opcode/funct and
// sequences mux selects and write strobes one step per clock, stalling on mem_ready.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q, state_d;
    logic       pc_write, branch;
    logic       mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_RTYPEEX;
                else if (opcode == OP_BEQ)              state_d = S_BEQEX;
                else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
                else if (opcode == OP_J)                state_d = S_JEX;
                else                                    state_d = S_FETCH;
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = 3'b000;
        PCSrc         = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ALUSrcB      = 2'b01;
                ALUControl   = ALU_ADD;
                ir_write_raw = mem_ready;
                pc_write     = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                IorD         = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'h20:   ALUControl = ALU_ADD;
                    6'h22:   ALUControl = ALU_SUB;
                    6'h24:   ALUControl = ALU_AND;
                    6'h25:   ALUControl = ALU_OR;
                    6'h2A:   ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            S_RTYPEWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_JEX: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Strobes are masked by reset so an aborted instruction never writes anything.
        MemRead  = mem_read_raw  & ~reset;
        MemWrite = mem_write_raw & ~reset;
        IRWrite  = ir_write_raw  & ~reset;
        RegWrite = reg_write_raw & ~reset;
        PCEn     = (pc_write | (branch & zero)) & ~reset;
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table plus hand-written
// sequences for latency and reset-abort corner cases.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic [16:0] ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .PCEn(PCEn), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign ctrl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn};

    function automatic logic [16:0] mk(input logic iord, mr, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic [1:0] pcs, input logic pcen);
        return {iord, mr, mw, irw, rd, m2r, rw, sa, sb, ac, pcs, pcen};
    endfunction

    // Hand-derived control words per state/condition.
    logic [16:0] F1, F0, FR, DEC, MADR, MRD, MRDR, MWB, MWR, RSUB, RADD, RWB, BEQ1, BEQ0,
                 AEX, AWB, JEX;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ex;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [16:0] ex);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic measure(input string name, input logic [5:0] op, input int exp);
        int n;
        opcode = op; mem_ready = 1'b1; zero = 1'b0; funct = 6'h20;
        n = 1;
        step();
        while (state_o != 4'd0 && n < 20) begin
            step();
            n++;
        end
        check(name, 17'(n), 17'(exp));
    endtask

    initial begin
        F1   = mk(0,1,0,1,0,0,0,0,2'b01,3'b010,2'b00,1);
        F0   = mk(0,1,0,0,0,0,0,0,2'b01,3'b010,2'b00,0);
        FR   = mk(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0);
        DEC  = mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0);
        MADR = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
        MRD  = mk(1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        MRDR = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        MWB  = mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
        MWR  = mk(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
        RSUB = mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0);
        RADD = mk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
        RWB  = mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
        BEQ1 = mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1);
        BEQ0 = mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
        AEX  = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
        AWB  = mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0);
        JEX  = mk(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1);

        // reset held, then lw straight through
        add(1,6'h23,6'h20,0,1, 0, FR);
        add(1,6'h23,6'h20,0,1, 0, FR);
        add(0,6'h23,6'h20,0,1, 0, F1);
        add(0,6'h23,6'h20,0,1, 1, DEC);
        add(0,6'h23,6'h20,0,1, 2, MADR);
        add(0,6'h23,6'h20,0,1, 3, MRD);
        add(0,6'h23,6'h20,0,1, 4, MWB);
        // sw with three stall cycles in MEMWR
        add(0,6'h2B,6'h20,0,1, 0, F1);
        add(0,6'h2B,6'h20,0,1, 1, DEC);
        add(0,6'h2B,6'h20,0,1, 2, MADR);
        add(0,6'h2B,6'h20,0,0, 5, MWR);
        add(0,6'h2B,6'h20,0,0, 5, MWR);
        add(0,6'h2B,6'h20,0,0, 5, MWR);
        add(0,6'h2B,6'h20,0,1, 5, MWR);
        // R-type sub, then unknown funct defaults to add
        add(0,6'h00,6'h22,0,1, 0, F1);
        add(0,6'h00,6'h22,0,1, 1, DEC);
        add(0,6'h00,6'h22,0,1, 6, RSUB);
        add(0,6'h00,6'h22,0,1, 7, RWB);
        add(0,6'h00,6'h3F,0,1, 0, F1);
        add(0,6'h00,6'h3F,0,1, 1, DEC);
        add(0,6'h00,6'h3F,0,1, 6, RADD);
        add(0,6'h00,6'h3F,0,1, 7, RWB);
        // beq taken / not taken
        add(0,6'h04,6'h20,1,1, 0, F1);
        add(0,6'h04,6'h20,1,1, 1, DEC);
        add(0,6'h04,6'h20,1,1, 8, BEQ1);
        add(0,6'h04,6'h20,0,1, 0, F1);
        add(0,6'h04,6'h20,0,1, 1, DEC);
        add(0,6'h04,6'h20,0,1, 8, BEQ0);
        // addi, j
        add(0,6'h08,6'h20,0,1, 0, F1);
        add(0,6'h08,6'h20,0,1, 1, DEC);
        add(0,6'h08,6'h20,0,1, 9, AEX);
        add(0,6'h08,6'h20,0,1,10, AWB);
        add(0,6'h02,6'h20,0,1, 0, F1);
        add(0,6'h02,6'h20,0,1, 1, DEC);
        add(0,6'h02,6'h20,0,1,11, JEX);
        // unknown opcode is a NOP; then fetch stalls
        add(0,6'h3F,6'h20,0,1, 0, F1);
        add(0,6'h3F,6'h20,0,1, 1, DEC);
        add(0,6'h23,6'h20,0,0, 0, F0);
        add(0,6'h23,6'h20,0,0, 0, F0);
        add(0,6'h23,6'h20,0,1, 0, F1);
        add(0,6'h23,6'h20,0,1, 1, DEC);
        add(0,6'h23,6'h20,0,1, 2, MADR);
        add(0,6'h23,6'h20,0,0, 3, MRD);
        // reset in MEMRD aborts the load
        add(1,6'h23,6'h20,0,0, 3, MRDR);
        add(0,6'h23,6'h20,0,1, 0, F1);

        reset = 1'b1; opcode = 6'h23; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 17'(state_o), 17'(vecs[i].st));
            check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].ex);
            step();
        end

        // latency from FETCH back to FETCH with mem_ready tied high
        do_reset();
        measure("lat_lw",   6'h23, 5);
        measure("lat_sw",   6'h2B, 4);
        measure("lat_r",    6'h00, 4);
        measure("lat_addi", 6'h08, 4);
        measure("lat_beq",  6'h04, 3);
        measure("lat_j",    6'h02, 3);
        measure("lat_nop",  6'h3F, 2);

        // reset arriving in MEMWB must suppress the register write
        do_reset();
        opcode = 6'h23; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("wb_state", 17'(state_o), 17'd4);
        check("wb_regwrite", 17'(RegWrite), 17'd1);
        reset = 1'b1;
        #1;
        check("wb_rst_regwrite", 17'(RegWrite), 17'd0);
        step();
        check("wb_rst_state", 17'(state_o), 17'd0);
        check("wb_rst_ctrl", ctrl, FR);
        reset = 1'b0;
        #1;
        check("post_rst_ctrl", ctrl, F1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
